// File: rtl/servo_pkg.sv
// Shared definitions for the servo pulse-length path: default timing and
// range constants, the controller state encoding (also used by the PWM stage
// so both sides agree on frame timing) and the range clamp helper.
package servo_pkg;

  localparam int CLK_F_DEF     = 50;
  localparam int PERIOD_US_DEF = 20000;
  localparam int MIN_US_DEF    = 1000;
  localparam int MAX_US_DEF    = 2000;
  localparam int INIT_US_DEF   = 1500;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } servo_state_e;

  // Limit a requested pulse length to the legal [lo, hi] window.
  function automatic logic [15:0] clamp_us(input logic [15:0] val,
                                           input logic [15:0] lo,
                                           input logic [15:0] hi);
    logic [15:0] res;
    if (val < lo) begin
      res = lo;
    end else if (val > hi) begin
      res = hi;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_frame_tick.sv
// Frame timebase: a prescaler dividing CLK down to microseconds and a
// microsecond counter spanning one servo frame. frame_tick is registered and
// is high exactly while both counters sit on their terminal counts.
module servo_frame_tick
  import servo_pkg::*;
#(
  parameter int CLK_F     = CLK_F_DEF,
  parameter int PERIOD_US = PERIOD_US_DEF
) (
  input  logic CLK,
  input  logic RST,
  output logic frame_tick
);

  localparam int PW = (CLK_F > 1) ? $clog2(CLK_F) : 1;
  localparam int UW = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_F - 1);
  localparam logic [UW-1:0] US_LAST  = UW'(PERIOD_US - 1);

  logic [PW-1:0] pre_r;
  logic [PW-1:0] pre_nx_s;
  logic [UW-1:0] us_r;
  logic [UW-1:0] us_nx_s;
  logic          tick_r;

  // Next counter values: microseconds advance only when the prescaler wraps.
  always_comb begin
    pre_nx_s = pre_r;
    us_nx_s  = us_r;
    if (pre_r == PRE_LAST) begin
      pre_nx_s = {PW{1'b0}};
      if (us_r == US_LAST) begin
        us_nx_s = {UW{1'b0}};
      end else begin
        us_nx_s = us_r + UW'(1);
      end
    end else begin
      pre_nx_s = pre_r + PW'(1);
    end
  end

  // Counter and tick registers; the tick is decoded from the next counts so it lines up with them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_r  <= {PW{1'b0}};
      us_r   <= {UW{1'b0}};
      tick_r <= 1'b0;
    end else begin
      pre_r  <= pre_nx_s;
      us_r   <= us_nx_s;
      tick_r <= (pre_nx_s == PRE_LAST) && (us_nx_s == US_LAST);
    end
  end

  assign frame_tick = tick_r;

endmodule

// File: rtl/servo_ramp.sv
// Servo pulse-length controller. Accepts a target pulse length over a
// valid/ready handshake, clamps it to [MIN_US, MAX_US] and moves the
// registered pulse_len toward it only on frame boundaries.
// Build option SERVO_RAMP_LIMIT_EN: when defined, pulse_len moves at most
// STEP_US per frame; when undefined, it jumps to the target at the first
// frame boundary and STEP_US has no effect.
module servo_ramp
  import servo_pkg::*;
#(
  parameter int CLK_F     = CLK_F_DEF,
  parameter int PERIOD_US = PERIOD_US_DEF,
  parameter int MIN_US    = MIN_US_DEF,
  parameter int MAX_US    = MAX_US_DEF,
  parameter int INIT_US   = INIT_US_DEF,
  parameter int STEP_US   = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] target_us,
  input  logic        target_valid,
  output logic        target_ready,
  output logic [15:0] pulse_len,
  output logic        frame_tick,
  output logic        at_target
);

  localparam logic [15:0] MIN_W  = 16'(MIN_US);
  localparam logic [15:0] MAX_W  = 16'(MAX_US);
  localparam logic [15:0] INIT_W = 16'(INIT_US);

  servo_state_e state_r;
  servo_state_e state_nx_s;
  logic [15:0]  pulse_r;
  logic [15:0]  pulse_nx_s;
  logic [15:0]  target_r;
  logic [15:0]  target_nx_s;
  logic         ready_r;
  logic         ready_nx_s;
  logic         at_target_r;
  logic         at_target_nx_s;
  logic         tick_s;

`ifdef SERVO_RAMP_LIMIT_EN
  localparam logic [15:0]        STEP_W = 16'(STEP_US);
  localparam logic signed [16:0] STEP_S = 17'(STEP_US);
  logic signed [16:0] diff_s;
  logic signed [16:0] mag_s;
`endif

  servo_frame_tick #(
    .CLK_F     (CLK_F),
    .PERIOD_US (PERIOD_US)
  ) u_frame_tick (
    .CLK        (CLK),
    .RST        (RST),
    .frame_tick (tick_s)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state, next pulse/target values and next handshake/status flags.
  always_comb begin
    state_nx_s  = state_r;
    pulse_nx_s  = pulse_r;
    target_nx_s = target_r;
`ifdef SERVO_RAMP_LIMIT_EN
    // 17-bit signed distance so no pair of 16-bit operands can wrap.
    diff_s = $signed({1'b0, target_r}) - $signed({1'b0, pulse_r});
    if (diff_s[16]) begin
      mag_s = -diff_s;
    end else begin
      mag_s = diff_s;
    end
`endif
    case (state_r)
      IDLE: begin
        if (target_valid && ready_r) begin
          target_nx_s = clamp_us(target_us, MIN_W, MAX_W);
          state_nx_s  = RAMP;
        end else begin
          state_nx_s  = IDLE;
        end
      end
      RAMP: begin
        if (tick_s) begin
`ifdef SERVO_RAMP_LIMIT_EN
          if (mag_s <= STEP_S) begin
            pulse_nx_s = target_r;
            state_nx_s = IDLE;
          end else if (diff_s[16]) begin
            pulse_nx_s = pulse_r - STEP_W;
          end else begin
            pulse_nx_s = pulse_r + STEP_W;
          end
`else
          pulse_nx_s = target_r;
          state_nx_s = IDLE;
`endif
        end else begin
          state_nx_s = RAMP;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
    ready_nx_s     = (state_nx_s == IDLE);
    at_target_nx_s = (state_nx_s == IDLE) && (pulse_nx_s == target_nx_s);
  end

  // Datapath and output registers; ready stays low for the first cycle after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pulse_r     <= INIT_W;
      target_r    <= INIT_W;
      ready_r     <= 1'b0;
      at_target_r <= 1'b1;
    end else begin
      pulse_r     <= pulse_nx_s;
      target_r    <= target_nx_s;
      ready_r     <= ready_nx_s;
      at_target_r <= at_target_nx_s;
    end
  end

  assign target_ready = ready_r;
  assign pulse_len    = pulse_r;
  assign frame_tick   = tick_s;
  assign at_target    = at_target_r;

endmodule

// File: tb/tb_servo_ramp.sv
// Self-checking bench for servo_ramp (CLK_F=2, PERIOD_US=20: one frame every
// 40 cycles). A frame-level reference model predicts pulse_len, the
// handshake and the status flags; it follows SERVO_RAMP_LIMIT_EN like the DUT.
module tb_servo_ramp;

  localparam int FRAME = 40;
`ifdef SERVO_RAMP_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] target_us = 16'd0;
  logic        target_valid = 1'b0;
  logic        target_ready;
  logic [15:0] pulse_len;
  logic        frame_tick;
  logic        at_target;

  servo_ramp #(
    .CLK_F(2), .PERIOD_US(20), .MIN_US(1000), .MAX_US(2000),
    .INIT_US(1500), .STEP_US(10)
  ) dut (
    .CLK(CLK), .RST(RST), .target_us(target_us), .target_valid(target_valid),
    .target_ready(target_ready), .pulse_len(pulse_len),
    .frame_tick(frame_tick), .at_target(at_target)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // Reference model state.
  int since_rst = 0;
  int m_pulse = 1500;
  int m_tgt = 1500;
  bit m_busy = 1'b0;
  bit m_after_rst = 1'b1;

  function automatic int clamp_ref(input int v);
    if (v < 1000) return 1000;
    if (v > 2000) return 2000;
    return v;
  endfunction

  function automatic int approach(input int p, input int t);
    int d;
    d = (t > p) ? (t - p) : (p - t);
    if (!LIMIT || d <= 10) return t;
    return (t > p) ? p + 10 : p - 10;
  endfunction

  function automatic bit m_ready();
    return !m_busy && !m_after_rst;
  endfunction

  function automatic logic [18:0] model_vec();
    logic [15:0] p;
    logic t;
    p = m_pulse[15:0];
    t = ((since_rst % FRAME) == FRAME - 1);
    return {p, m_ready(), !m_busy, t};
  endfunction

  // Advance one clock, updating the model from the inputs of the current cycle.
  task automatic advance();
    bit tick_now;
    bit accept;
    tick_now = ((since_rst % FRAME) == FRAME - 1);
    accept = target_valid && m_ready();
    if (RST) begin
      m_pulse = 1500; m_tgt = 1500; m_busy = 1'b0;
    end else if (m_busy && tick_now) begin
      m_pulse = approach(m_pulse, m_tgt);
      if (m_pulse == m_tgt) m_busy = 1'b0;
    end else if (accept) begin
      m_tgt = clamp_ref(int'(target_us));
      m_busy = 1'b1;
    end
    since_rst = RST ? 0 : since_rst + 1;
    m_after_rst = RST;
    @(posedge CLK);
    #1;
  endtask

  // Offer one target and hold it until the model says it is taken.
  task automatic offer(input logic [15:0] v);
    for (int i = 0; i < 10000 && !m_ready(); i++) advance();
    target_us = v;
    target_valid = 1'b1;
    advance();
    target_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    target_valid = 1'b0;
    repeat (3) advance();
    RST = 1'b0;
    total++; if (pulse_len !== 16'd1500) begin bad++; $display("FAIL rst_pulse got=%0d exp=1500", pulse_len); end
    total++; if (at_target !== 1'b1) begin bad++; $display("FAIL rst_at_target got=%b exp=1", at_target); end
    total++; if (target_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", target_ready); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b exp=0", frame_tick); end
    advance();
    total++; if (target_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_rise got=%b exp=1", target_ready); end
    for (int i = 1; i < 39; i++) begin
      advance();
      total++; if ({pulse_len, target_ready, at_target, frame_tick} !== model_vec()) begin
        bad++; $display("FAIL rst_walk cyc=%0d got=%h exp=%h", since_rst, {pulse_len, target_ready, at_target, frame_tick}, model_vec());
      end
    end
    total++; if (frame_tick !== 1'b1 || since_rst != 39) begin bad++; $display("FAIL first_tick cyc=%0d got=%b exp=1@39", since_rst, frame_tick); end
  endtask

  task automatic test_ramp();
    int seen[$];
    int exp_seq[$];
    int last;
    if (LIMIT) exp_seq = '{1510, 1520, 1530}; else exp_seq = '{1900};
    offer(LIMIT ? 16'd1530 : 16'd1900);
    last = int'(pulse_len);
    for (int i = 0; i < 400; i++) begin
      advance();
      total++; if ({pulse_len, target_ready, at_target, frame_tick} !== model_vec()) begin
        bad++; $display("FAIL ramp cyc=%0d got=%h exp=%h", since_rst, {pulse_len, target_ready, at_target, frame_tick}, model_vec());
      end
      if (int'(pulse_len) != last) begin seen.push_back(int'(pulse_len)); last = int'(pulse_len); end
      if (at_target === 1'b1) break;
    end
    total++; if (at_target !== 1'b1) begin bad++; $display("FAIL ramp_timeout got=%b exp=1", at_target); end
    total++; if (seen.size() != exp_seq.size()) begin bad++; $display("FAIL ramp_steps got=%0d exp=%0d", seen.size(), exp_seq.size()); end
    for (int i = 0; i < seen.size() && i < exp_seq.size(); i++) begin
      total++; if (seen[i] != exp_seq[i]) begin bad++; $display("FAIL ramp_seq idx=%0d got=%0d exp=%0d", i, seen[i], exp_seq[i]); end
    end
  endtask

  task automatic test_clamp(input logic [15:0] req, input int want, input int bound);
    offer(req);
    for (int i = 0; i < bound; i++) begin
      advance();
      total++; if ({pulse_len, target_ready, at_target, frame_tick} !== model_vec()) begin
        bad++; $display("FAIL clamp cyc=%0d got=%h exp=%h", since_rst, {pulse_len, target_ready, at_target, frame_tick}, model_vec());
      end
      if (at_target === 1'b1) break;
    end
    total++; if (pulse_len !== want[15:0] || at_target !== 1'b1) begin
      bad++; $display("FAIL clamp_final req=%0d got=%0d exp=%0d", req, pulse_len, want);
    end
    repeat (FRAME + 2) advance();
    total++; if (pulse_len !== want[15:0]) begin bad++; $display("FAIL clamp_stop got=%0d exp=%0d", pulse_len, want); end
  endtask

  task automatic test_handshake();
    bit accepted;
    accepted = 1'b0;
    offer(16'd1650);
    target_us = 16'd1700;
    target_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (target_ready === 1'b1) accepted = 1'b1;
      advance();
      total++; if ({pulse_len, target_ready, at_target, frame_tick} !== model_vec()) begin
        bad++; $display("FAIL hs cyc=%0d got=%h exp=%h", since_rst, {pulse_len, target_ready, at_target, frame_tick}, model_vec());
      end
      if (accepted) break;
    end
    target_valid = 1'b0;
    total++; if (accepted !== 1'b1 || pulse_len !== 16'd1650) begin bad++; $display("FAIL hs_accept got=%b/%0d exp=1/1650", accepted, pulse_len); end
    total++; if (target_ready !== 1'b0 || at_target !== 1'b0) begin bad++; $display("FAIL hs_reenter got=%b%b exp=00", target_ready, at_target); end
    for (int i = 0; i < 1000 && at_target !== 1'b1; i++) begin
      advance();
      total++; if ({pulse_len, target_ready, at_target, frame_tick} !== model_vec()) begin
        bad++; $display("FAIL hs2 cyc=%0d got=%h exp=%h", since_rst, {pulse_len, target_ready, at_target, frame_tick}, model_vec());
      end
    end
    total++; if (pulse_len !== 16'd1700 || at_target !== 1'b1) begin bad++; $display("FAIL hs_final got=%0d exp=1700", pulse_len); end
  endtask

  task automatic test_reset_mid_ramp();
    bit reached;
    int moved;
    RST = 1'b1; advance(); RST = 1'b0;
    offer(16'd2000);
    for (int i = 0; i < 1000; i++) begin
      if (pulse_len === 16'd1560 || (!LIMIT && i >= 5)) break;
      advance();
      total++; if ({pulse_len, target_ready, at_target, frame_tick} !== model_vec()) begin
        bad++; $display("FAIL mid cyc=%0d got=%h exp=%h", since_rst, {pulse_len, target_ready, at_target, frame_tick}, model_vec());
      end
    end
    reached = (pulse_len === 16'd1560);
    total++; if (reached != LIMIT) begin bad++; $display("FAIL mid_reach got=%b exp=%b", reached, LIMIT); end
    RST = 1'b1; advance(); RST = 1'b0;
    total++; if (pulse_len !== 16'd1500) begin bad++; $display("FAIL mid_rst_pulse got=%0d exp=1500", pulse_len); end
    total++; if (at_target !== 1'b1 || target_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_flags got=%b%b exp=10", at_target, target_ready); end
    moved = 0;
    for (int i = 0; i < 200; i++) begin
      advance();
      if (pulse_len !== 16'd1500) moved++;
    end
    total++; if (moved != 0) begin bad++; $display("FAIL mid_no_steps got=%0d exp=0", moved); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 399) == 0);
      target_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) target_us = 16'($urandom_range(0, 65535));
      else target_us = 16'($urandom_range(900, 2100));
      advance();
      total++; if ({pulse_len, target_ready, at_target, frame_tick} !== model_vec()) begin
        bad++; $display("FAIL rand cyc=%0d got=%h exp=%h", since_rst, {pulse_len, target_ready, at_target, frame_tick}, model_vec());
      end
    end
    RST = 1'b0;
    target_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_clamp(16'd50, 1000, 4000);
    test_clamp(16'd65535, 2000, 6000);
    test_handshake();
    test_reset_mid_ramp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servo_ramp.md
SERVO_RAMP -- requirements
Module: servo_ramp

Interface
REQ-001 Parameter CLK_F, default 50: clock cycles per microsecond.
REQ-002 Parameter PERIOD_US, default 20000: servo frame length in microseconds.
REQ-003 Parameter MIN_US, default 1000: lowest legal pulse length in microseconds.
REQ-004 Parameter MAX_US, default 2000: highest legal pulse length in microseconds.
REQ-005 Parameter INIT_US, default 1500: pulse length after reset.
REQ-006 Parameter STEP_US, default 10: maximum pulse-length change per frame.
REQ-007 The port list SHALL be:
  - CLK, input, 1 bit: the single clock.
  - RST, input, 1 bit: synchronous reset, active-high.
  - target_us, input, 16 bits: requested pulse length in microseconds.
  - target_valid, input, 1 bit: target_us is offered.
  - target_ready, output, 1 bit: the block accepts a target this cycle.
  - pulse_len, output, 16 bits: registered pulse length in microseconds, fed to the downstream PWM stage.
  - frame_tick, output, 1 bit: one-cycle pulse on the last cycle of each frame.
  - at_target, output, 1 bit: pulse_len equals the accepted target.

Function
REQ-008 The timebase SHALL be a prescaler counting 0..CLK_F-1 plus a microsecond counter.
  - The microsecond counter increments when the prescaler wraps.
  - It counts 0..PERIOD_US-1 and then wraps to 0.
REQ-009 frame_tick SHALL be high for exactly one cycle, when the prescaler equals CLK_F-1 and the microsecond counter equals PERIOD_US-1, i.e. every CLK_F*PERIOD_US cycles.
REQ-010 The FSM SHALL have two states, IDLE and RAMP.
  - target_ready is 1 only in IDLE and never during reset.
  - at_target is 1 only in IDLE.
REQ-011 A target SHALL be accepted on a cycle where target_valid=1 and target_ready=1.
  - On the next cycle the target register holds the clamped value and the state is RAMP.
REQ-012 Clamping SHALL work as follows:
  - target_us < MIN_US stores MIN_US.
  - target_us > MAX_US stores MAX_US.
  - Any other value is stored unchanged.
REQ-013 In RAMP, on each frame_tick cycle, with d = |target - pulse_len|:
  - d <= STEP_US: pulse_len <= target and the state becomes IDLE.
  - Otherwise pulse_len moves STEP_US toward target.
REQ-014 pulse_len SHALL change only on frame_tick cycles, so each downstream frame sees a stable value.
REQ-015 Accepting a target equal to pulse_len SHALL still enter RAMP, and the block completes at the next frame_tick.
REQ-016 A frame_tick on the same cycle as acceptance SHALL NOT step pulse_len; the first step occurs at the following frame_tick.
REQ-017 target_valid in RAMP SHALL be ignored.
  - The upstream block holds the target until target_ready is 1.
REQ-018 Step arithmetic SHALL use a 17-bit signed difference, so no wrap-around occurs for any 16-bit operands.

Reset
REQ-019 When RST=1 at a CLK edge, the block SHALL set:
  - state = IDLE;
  - pulse_len = INIT_US;
  - target register = INIT_US;
  - prescaler = 0 and microsecond counter = 0;
  - frame_tick = 0 and target_ready = 0.
REQ-020 Reset mid-ramp SHALL abandon the ramp.
  - pulse_len returns to INIT_US on the cycle after RST.
  - target_ready rises on the first cycle after RST deasserts.

Configuration
REQ-021 With macro SERVO_RAMP_LIMIT_EN defined, the block SHALL behave per REQ-013.
REQ-022 Without SERVO_RAMP_LIMIT_EN, at the first frame_tick in RAMP the block SHALL:
  - set pulse_len to the full clamped target;
  - return to IDLE.
  - STEP_US is unused in this build.

Structure
REQ-023 Package servo_pkg SHALL hold:
  - default CLK_F, PERIOD_US, MIN_US, MAX_US and INIT_US;
  - the FSM state encoding, shared with the PWM stage for consistent frame timing.
REQ-024 The timebase SHALL be sub-module servo_frame_tick (CLK, RST -> frame_tick), parameterised by CLK_F and PERIOD_US.

Verification
Unless stated otherwise, the bench uses CLK_F=2 and PERIOD_US=20, so frame_tick occurs every 40 cycles.
REQ-025 Reset release:
  - Stimulus: release RST and count cycles.
  - Response: pulse_len=1500, at_target=1, and the first frame_tick falls on cycle 39 after release.
REQ-026 Ramp up:
  - Stimulus: accept target_us=1530 with STEP_US=10.
  - Response: pulse_len is 1510, then 1520, then 1530 on three successive frame_ticks; at_target rises with the 1530 update.
REQ-027 Clamp:
  - Stimulus 1: target_us=50. Response: pulse_len ramps down to 1000 and stops.
  - Stimulus 2: target_us=65535. Response: pulse_len ramps up to 2000 and stops.
REQ-028 Handshake:
  - Stimulus: hold target_valid=1 with 1700 during RAMP.
  - Response: target_ready=0 throughout RAMP; 1700 is accepted on the first cycle back in IDLE.
REQ-029 Reset mid-ramp:
  - Stimulus: assert RST while pulse_len=1560 and target=2000.
  - Response: pulse_len=1500 on the next cycle, state IDLE, and no further steps occur.
REQ-030 Build without the macro:
  - Stimulus: SERVO_RAMP_LIMIT_EN undefined, accept target_us=1900.
  - Response: pulse_len jumps 1500 -> 1900 at the first frame_tick after acceptance.
